// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - default address / data widths
//   - header length of the load stream (word count, little-endian)
//   - loader FSM state enumeration
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int HDR_LEN    = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_LO  = 3'd1,
        S_HDR_HI  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_WRITE   = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

endpackage

// File: rtl/imem_loader_wordasm.sv
// -----------------------------------------------------------------------------
// imem_loader_wordasm
// Assembles payload bytes (MSB first) into instruction words and keeps the
// running XOR of every payload byte.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           restart for a new load (clears word, checksum, byte index)
//   shift         a payload byte is being accepted this cycle
//   byte_data     the payload byte
//   word          assembled word (valid once four bytes have been shifted)
//   csum          XOR of all payload bytes since clr
//   byte_last     the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module imem_loader_wordasm
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word,
    output logic [7:0]        csum,
    output logic              byte_last
);

    logic [DATA_W-1:0] word_q;
    logic [7:0]        csum_q;
    logic [1:0]        idx_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_q <= '0;
            csum_q <= '0;
            idx_q  <= '0;
        end else if (shift) begin
            word_q <= {word_q[DATA_W-9:0], byte_data};
            csum_q <= csum_q ^ byte_data;
            idx_q  <= idx_q + 2'd1;  // wraps to 0 after byte 3, ready for next word
        end
    end

    assign word      = word_q;
    assign csum      = csum_q;
    assign byte_last = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads an instruction RAM from a byte stream while holding the CPU in stall.
// Stream: count_lo, count_hi (word count N), N words of 4 bytes MSB first,
// then one checksum byte equal to the XOR of all payload bytes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, starts a load (only honoured in idle)
//   byte_valid/ready    byte stream handshake, byte_data carries the byte
//   wr_en/addr/data     one-cycle instruction RAM write
//   cpu_hold            CPU stall while a load is in progress
//   done                one-cycle pulse on a successful load
//   error               sticky error flag, cleared by start or reset
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Largest legal word count; 17 bits so that ADDR_W=16 still fits.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   cnt_q;     // one extra bit: reaches N without wrapping
    logic              error_q;

    logic              accept;
    logic [15:0]       hdr_n;
    logic              hdr_bad;
    logic              last_word;
    logic              asm_clr;
    logic              asm_shift;
    logic [DATA_W-1:0] asm_word;
    logic [7:0]        asm_csum;
    logic              asm_last;

    assign accept    = byte_valid & byte_ready;
    // Full count as it becomes known when the high byte is accepted.
    assign hdr_n     = {byte_data, n_q[7:0]};
    assign hdr_bad   = (hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_WORDS);
    assign last_word = (17'(cnt_q) + 17'd1) == {1'b0, n_q};
    assign asm_clr   = (state_q == S_IDLE) && start;
    assign asm_shift = (state_q == S_PAYLOAD) && accept;

    imem_loader_wordasm #(
        .DATA_W (DATA_W)
    ) u_wordasm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .shift     (asm_shift),
        .byte_data (byte_data),
        .word      (asm_word),
        .csum      (asm_csum),
        .byte_last (asm_last)
    );

    // State register and load bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (asm_clr) begin
                error_q <= 1'b0;
                cnt_q   <= '0;
            end
            if (state_q == S_ERR) begin
                error_q <= 1'b1;
            end
            if ((state_q == S_HDR_LO) && accept) begin
                n_q[7:0] <= byte_data;
            end
            if ((state_q == S_HDR_HI) && accept) begin
                n_q[15:8] <= byte_data;
            end
            if (state_q == S_WRITE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state_q)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (start) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                byte_ready = 1'b1;
                if (accept) state_d = S_HDR_HI;
            end
            S_HDR_HI: begin
                byte_ready = 1'b1;
                if (accept) state_d = hdr_bad ? S_ERR : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                byte_ready = 1'b1;
                if (accept && asm_last) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                state_d = last_word ? S_CHECK : S_PAYLOAD;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                if (accept) state_d = (byte_data == asm_csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                cpu_hold = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                cpu_hold = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign wr_addr = cnt_q[ADDR_W-1:0];
    assign wr_data = asm_word;
    // Error is visible already in the ERR cycle, then held by the sticky flag.
    assign error   = error_q | (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench for imem_loader: the driver derives the expected writes and
// outcome of each stream from the stream format, a monitor checks every
// write strobe against the expected queue and counts done pulses.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW   = 10;
    localparam int MAXN = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic [AW+31:0] exp_q[$];

    imem_loader #(
        .ADDR_W (AW),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            logic [AW+31:0] e;
            chk("ready_in_write", 64'(byte_ready), 64'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 64'(wr_addr), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e[AW+31:32]));
                chk("wr_data", 64'(wr_data), 64'(e[31:0]));
            end
        end
        if (!rst && done) done_seen++;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
        chk({tag, "_wr_en"},      64'(wr_en),      64'(0));
        chk({tag, "_wr_addr"},    64'(wr_addr),    64'(0));
        chk({tag, "_wr_data"},    64'(wr_data),    64'(0));
        chk({tag, "_cpu_hold"},   64'(cpu_hold),   64'(0));
        chk({tag, "_done"},       64'(done),       64'(0));
        chk({tag, "_error"},      64'(error),      64'(0));
    endtask

    task automatic make_stream(input int n, input bit corrupt, output logic [7:0] s[$]);
        logic [7:0] cs;
        logic [7:0] b;
        s.delete();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            s.push_back(b);
        end
        s.push_back(corrupt ? (cs ^ 8'(1 + $urandom_range(254, 0))) : cs);
    endtask

    // reset_after >= 0: pulse reset after that many bytes were accepted.
    task automatic run_load(input logic [7:0] s[$], input int max_gap,
                            input int reset_after, input bit mid_start);
        int         n;
        bit         hdr_bad;
        int         nsend;
        logic [7:0] cs;
        logic [31:0] d;
        bit         exp_done;
        bit         exp_err;
        bit         ok;
        bit         acc;
        int         g;
        int         t;

        n       = int'(s[0]) | (int'(s[1]) << 8);
        hdr_bad = (n == 0) || (n > MAXN);
        nsend   = hdr_bad ? HDR_LEN : s.size();
        if (reset_after >= 0) nsend = reset_after;
        cs = 8'h00;
        if (!hdr_bad) begin
            for (int w = 0; w < n; w++) begin
                d  = {s[HDR_LEN+4*w], s[HDR_LEN+4*w+1], s[HDR_LEN+4*w+2], s[HDR_LEN+4*w+3]};
                cs = cs ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
                if (HDR_LEN + 4 * w + 4 <= nsend) exp_q.push_back({AW'(w), d});
            end
        end
        exp_done = !hdr_bad && (reset_after < 0) && (s[s.size()-1] == cs);
        exp_err  = (reset_after < 0) && !exp_done;
        done_seen = 0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("hold_after_start", 64'(cpu_hold), 64'(1));
        chk("error_cleared_by_start", 64'(error), 64'(0));
        @(posedge clk); #1;

        ok = 1'b1;
        for (int i = 0; i < nsend && ok; i++) begin
            g = int'($urandom_range(max_gap, 0));
            byte_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            byte_valid = 1'b1;
            byte_data  = s[i];
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 64) begin
                @(negedge clk);
                acc = byte_ready;
                @(posedge clk); #1;
                t++;
            end
            byte_valid = 1'b0;
            if (!acc) begin
                chk("byte_accept_timeout", 64'(i), 64'hFFFF);
                ok = 1'b0;
            end
            if (mid_start && i == 6) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end

        if (!ok || reset_after >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            if (ok) begin
                check_reset_outputs("midload_reset");
                chk("midload_pending_writes", 64'(exp_q.size()), 64'(0));
                chk("midload_done", 64'(done_seen), 64'(0));
            end
            exp_q.delete();
        end else begin
            t = 0;
            while (t < 40) begin
                @(negedge clk);
                if (!cpu_hold) break;
                t++;
            end
            chk("hold_released", 64'(cpu_hold), 64'(0));
            chk("error_flag", 64'(error), 64'(exp_err));
            chk("done_pulses", 64'(done_seen), 64'(exp_done));
            chk("pending_writes", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
            @(negedge clk);
            chk("idle_ready", 64'(byte_ready), 64'(0));
            chk("sticky_error", 64'(error), 64'(exp_err));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        logic [7:0] ref_s[$];

        rst        = 1'b1;
        start      = 1'b1;   // reset must win over start
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        @(posedge clk); #1;

        ref_s = '{8'h02, 8'h00, 8'h20, 8'h11, 8'h00, 8'h01, 8'h08, 8'h00, 8'h08, 8'h05, 8'h35};

        // Nominal two-word load
        run_load(ref_s, 0, -1, 1'b0);

        // Wrong checksum
        s = ref_s;
        s[10] = 8'h34;
        run_load(s, 0, -1, 1'b0);

        // Illegal headers
        s = '{8'h00, 8'h00};
        run_load(s, 0, -1, 1'b0);
        s = '{8'h01, 8'h04};
        run_load(s, 2, -1, 1'b0);

        // Random gaps on the nominal stream
        for (int k = 0; k < 3; k++) run_load(ref_s, 7, -1, 1'b0);

        // Reset after the 6th payload byte, then a full load
        run_load(ref_s, 1, 8, 1'b0);
        run_load(ref_s, 3, -1, 1'b0);

        // Start pulsed during payload
        run_load(ref_s, 2, -1, 1'b1);

        // Largest legal load
        make_stream(MAXN, 1'b0, s);
        run_load(s, 0, -1, 1'b0);

        // Random loads, some with a corrupted checksum
        for (int k = 0; k < 10; k++) begin
            make_stream(int'($urandom_range(6, 1)), ($urandom_range(3, 0) == 0), s);
            run_load(s, 3, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
